// File: rtl/vote_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vote_arbiter
//  Description : Round-robin arbiter over three requesters, each presenting a
//                three-bit vote word. The granted word is reduced to a 2-of-3
//                majority bit and held in a single-entry output slot with a
//                valid/ready handshake. Delivered "true" results are counted
//                in a saturating 8-bit counter.
//  Revision    : 1.0  initial release
// ============================================================================
module vote_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req_val,
  input  logic [8:0] req_bits,
  output logic [2:0] req_rdy,
  output logic       resp_val,
  input  logic       resp_rdy,
  output logic       resp_out,
  output logic [1:0] resp_id,
  output logic [7:0] true_cnt
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [7:0] C_CNT_MAX = 8'hFF;

  state_t     r_state;
  logic [1:0] r_ptr;
  logic       r_resp_out;
  logic [1:0] r_resp_id;
  logic [7:0] r_true_cnt;

  logic       w_open;
  logic       w_resp_xfer;
  logic [1:0] w_ord0;
  logic [1:0] w_ord1;
  logic [1:0] w_ord2;
  logic       w_gnt;
  logic [1:0] w_gnt_id;
  logic [2:0] w_req_rdy;
  logic [2:0] w_word;
  logic       w_maj;
  logic [1:0] w_ptr_nxt;

  // Slot accepts a new word when empty, or when the held result drains now.
  assign w_open      = (r_state == ST_EMPTY) || resp_rdy;
  assign w_resp_xfer = (r_state == ST_FULL) && resp_rdy;

  // Search order starts at the pointer and wraps modulo three.
  always_comb begin
    case (r_ptr)
      2'd1:    begin w_ord0 = 2'd1; w_ord1 = 2'd2; w_ord2 = 2'd0; end
      2'd2:    begin w_ord0 = 2'd2; w_ord1 = 2'd0; w_ord2 = 2'd1; end
      default: begin w_ord0 = 2'd0; w_ord1 = 2'd1; w_ord2 = 2'd2; end
    endcase
  end

  // Pick the first valid requester in search order; grants are suppressed
  // while the slot is closed or the block is held in reset.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_id  = 2'd0;
    w_req_rdy = 3'b000;
    if (w_open && rst_n) begin
      if (req_val[w_ord0]) begin
        w_gnt    = 1'b1;
        w_gnt_id = w_ord0;
      end else if (req_val[w_ord1]) begin
        w_gnt    = 1'b1;
        w_gnt_id = w_ord1;
      end else if (req_val[w_ord2]) begin
        w_gnt    = 1'b1;
        w_gnt_id = w_ord2;
      end
    end
    if (w_gnt) begin
      w_req_rdy[w_gnt_id] = 1'b1;
    end
  end

  // Select the granted requester's word and reduce it to a majority bit.
  always_comb begin
    case (w_gnt_id)
      2'd1:    w_word = req_bits[5:3];
      2'd2:    w_word = req_bits[8:6];
      default: w_word = req_bits[2:0];
    endcase
    w_maj     = (w_word[0] & w_word[1]) | (w_word[2] & (w_word[0] | w_word[1]));
    w_ptr_nxt = (w_gnt_id == 2'd2) ? 2'd0 : w_gnt_id + 2'd1;
  end

  // Slot FSM, round-robin pointer, held result and saturating true counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_ptr      <= 2'd0;
      r_resp_out <= 1'b0;
      r_resp_id  <= 2'd0;
      r_true_cnt <= 8'd0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_gnt) begin
            r_state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (resp_rdy && !w_gnt) begin
            r_state <= ST_EMPTY;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase

      if (w_gnt) begin
        r_resp_out <= w_maj;
        r_resp_id  <= w_gnt_id;
        r_ptr      <= w_ptr_nxt;
      end

      if (w_resp_xfer && r_resp_out && (r_true_cnt != C_CNT_MAX)) begin
        r_true_cnt <= r_true_cnt + 8'd1;
      end
    end
  end

  assign req_rdy  = w_req_rdy;
  assign resp_val = (r_state == ST_FULL);
  assign resp_out = r_resp_out;
  assign resp_id  = r_resp_id;
  assign true_cnt = r_true_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vote_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vote_arbiter
//  Description : Directed bench for vote_arbiter. A reference model predicts
//                each grant; granted results are pushed to a scoreboard queue
//                and compared against the output slot while it is valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vote_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req_val;
  logic [8:0] req_bits;
  logic [2:0] req_rdy;
  logic       resp_val;
  logic       resp_rdy;
  logic       resp_out;
  logic [1:0] resp_id;
  logic [7:0] true_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Scoreboard entries are {resp_out, resp_id}.
  logic [2:0] sb_q[$];
  int         m_ptr;
  bit         m_full;
  int         m_cnt;

  vote_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_val  (req_val),
    .req_bits (req_bits),
    .req_rdy  (req_rdy),
    .resp_val (resp_val),
    .resp_rdy (resp_rdy),
    .resp_out (resp_out),
    .resp_id  (resp_id),
    .true_cnt (true_cnt)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic maj(input logic [2:0] w);
    return ($countones(w) >= 2);
  endfunction

  // One clock: check DUT at the falling edge, advance the model, then step
  // to just after the next rising edge.
  task automatic cycle();
    logic [2:0] exp_rdy;
    logic [2:0] ent;
    int         gid;
    @(negedge clk);
    exp_rdy = 3'b000;
    gid     = -1;
    if (rst_n && (!m_full || resp_rdy)) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_ptr + k) % 3;
        if (gid < 0 && req_val[idx]) gid = idx;
      end
    end
    if (gid >= 0) exp_rdy[gid] = 1'b1;
    chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
    chk("resp_val", 32'(resp_val), 32'(m_full));
    chk("true_cnt", 32'(true_cnt), 32'(m_cnt));
    if (m_full && sb_q.size() > 0) begin
      chk("resp_out_id", 32'({resp_out, resp_id}), 32'(sb_q[0]));
    end
    if (!rst_n) begin
      sb_q.delete();
      m_full = 1'b0;
      m_ptr  = 0;
      m_cnt  = 0;
    end else begin
      if (m_full && resp_rdy) begin
        ent = sb_q.pop_front();
        if (ent[2] && m_cnt < 255) m_cnt = m_cnt + 1;
        m_full = 1'b0;
      end
      if (gid >= 0) begin
        ent = {maj(req_bits[3*gid +: 3]), 2'(gid)};
        sb_q.push_back(ent);
        m_full = 1'b1;
        m_ptr  = (gid + 1) % 3;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] tbl;
    tbl      = 8'b1110_1000;
    rst_n    = 1'b0;
    req_val  = 3'b000;
    req_bits = 9'd0;
    resp_rdy = 1'b0;
    m_ptr    = 0;
    m_full   = 1'b0;
    m_cnt    = 0;

    // Bring the DUT out of its unknown power-up state.
    repeat (2) @(posedge clk);
    #1;
    cycle();
    chk("rst_resp_out", 32'(resp_out), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);

    // Single requester 0, word 011.
    rst_n    = 1'b1;
    req_val  = 3'b001;
    req_bits = 9'b000_000_011;
    resp_rdy = 1'b1;
    cycle();
    req_val = 3'b000;
    chk("first_val", 32'(resp_val), 32'd1);
    chk("first_out", 32'(resp_out), 32'd1);
    chk("first_id", 32'(resp_id), 32'd0);
    cycle();
    chk("first_cnt", 32'(true_cnt), 32'd1);

    // All three valid back to back, one result per cycle.
    do_reset();
    req_val  = 3'b111;
    req_bits = {3'b111, 3'b110, 3'b100};
    resp_rdy = 1'b1;
    repeat (9) cycle();

    // Backpressure with a held result, then release.
    resp_rdy = 1'b0;
    repeat (4) cycle();
    resp_rdy = 1'b1;
    repeat (3) cycle();

    // Full vote table through requester 2.
    for (int w = 0; w < 8; w++) begin
      req_val  = 3'b100;
      req_bits = {3'(w), 6'b000_000};
      cycle();
      chk("vote_tbl", 32'(resp_out), 32'(tbl[w]));
    end
    req_val = 3'b000;
    cycle();

    // Saturation of the true counter.
    do_reset();
    req_val  = 3'b001;
    req_bits = 9'b000_000_011;
    resp_rdy = 1'b1;
    repeat (302) cycle();
    req_val = 3'b000;
    repeat (2) cycle();
    chk("sat_cnt", 32'(true_cnt), 32'd255);
    cycle();
    chk("sat_hold", 32'(true_cnt), 32'd255);

    // Reset while holding a result under backpressure.
    resp_rdy = 1'b0;
    req_val  = 3'b010;
    req_bits = 9'b000_111_000;
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n    = 1'b1;
    req_val  = 3'b000;
    resp_rdy = 1'b1;
    chk("rst_mid_val", 32'(resp_val), 32'd0);
    chk("rst_mid_cnt", 32'(true_cnt), 32'd0);
    cycle();
    req_val = 3'b111;
    cycle();
    chk("rst_ptr_id", 32'(resp_id), 32'd0);
    repeat (3) cycle();
    req_val = 3'b000;
    repeat (2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
